seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SHOW_CYCLES, default 99000: the number of clocks each digit is driven per slot.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 1000: the number of clocks of dead time with all anodes off before each digit slot.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: the scan run enable.
REQ-006 The block SHALL have port load, input, 1 bit: the new-display-data request.
REQ-007 The block SHALL have port load_data, input, 16 bits: the digit nibbles; [15:12]=A (leftmost), [11:8]=B, [7:4]=C, [3:0]=D.
REQ-008 The block SHALL have port digit_en, input, 4 bits: the per-digit enable mask; [3]=A, [2]=B, [1]=C, [0]=D.
REQ-009 The block SHALL have port load_ready, output, 1 bit: high when a load will be accepted.
REQ-010 The block SHALL have ports A, B, C, D, outputs, 4 bits each: the committed digit values fed to the seven-segment decoder.
REQ-011 The block SHALL have port disp_sel, output, 4 bits: the one-hot digit select; 1000=A, 0100=B, 0010=C, 0001=D, 0000=all anodes off.
REQ-012 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse at the end of each frame.

Function
REQ-013 The block SHALL implement two phase states (BLANK, SHOW), a 2-bit slot index idx (0=A..3=D) and one phase counter.
REQ-014 In BLANK, disp_sel SHALL be 0000, and the counter SHALL run 0..BLANK_CYCLES-1 before the block moves to SHOW with the counter cleared.
REQ-015 In SHOW, the counter SHALL run 0..SHOW_CYCLES-1 before the block moves to BLANK with the counter cleared and idx incremented; idx SHALL wrap from 3 to 0.
REQ-016 In SHOW, disp_sel SHALL be the one-hot code for idx if digit_en[3-idx]=1, and 0000 otherwise; a disabled digit SHALL still consume its full slot so per-digit duty stays constant.
REQ-017 disp_sel, load_ready and frame_done SHALL be functions of registered state only, with no combinational path from any input.
REQ-018 One frame SHALL be 4*(BLANK_CYCLES+SHOW_CYCLES) clocks, and frame_done SHALL be high during exactly the last SHOW cycle of idx=3.
REQ-019 A load with load_ready=1 SHALL capture load_data into a pending register, set the pending flag and drive load_ready=0 on the next cycle.
REQ-020 A load with load_ready=0 SHALL be ignored; the pending data SHALL NOT be overwritten.
REQ-021 The pending flag SHALL only be cleared at a commit, when A..D are loaded from the pending register.
REQ-022 While enable=1, a commit SHALL occur only at the clock edge ending a frame_done cycle, so no frame shows mixed old and new data.
REQ-023 When a load is accepted on the same edge as a frame boundary with pending=0, the data SHALL be held as pending and committed at the following frame boundary.
REQ-024 While enable=0, the block SHALL synchronously force state to BLANK, idx=0 and counter=0, with disp_sel=0000 and frame_done=0.
REQ-025 While enable=0, any pending data SHALL commit on the next clock edge.
REQ-026 On the rise of enable, scanning SHALL restart from BLANK with idx=0.
REQ-027 digit_en changes SHALL take effect on the next cycle with no effect on slot timing.
REQ-028 Both parameters SHALL be at least 1, and the counter width SHALL be sized for max(SHOW_CYCLES, BLANK_CYCLES)-1.

Reset
REQ-029 While reset=1, asynchronously: state=BLANK, idx=0, counter=0, disp_sel=0000, A=B=C=D=4'h0, pending=0, load_ready=1, frame_done=0.
REQ-030 Reset asserted mid-slot or mid-pending SHALL discard the pending data.
REQ-031 After reset deassertion with enable=1, the first SHOW cycle (disp_sel=1000) SHALL occur BLANK_CYCLES clocks after the first active edge.

Verification (SHOW_CYCLES=4, BLANK_CYCLES=2, enable=1, digit_en=1111 unless stated)
REQ-032 Release reset -> disp_sel sequence per 24-cycle frame: 0000 x2, 1000 x4, 0000 x2, 0100 x4, 0000 x2, 0010 x4, 0000 x2, 0001 x4; frame_done high on cycle 24 only; then repeats.
REQ-033 Load with load_data=16'h1234 mid-slot B -> load_ready=0 the next cycle; A..D stay 0 until the edge after frame_done, then A=1, B=2, C=3, D=4 and load_ready=1.
REQ-034 Second load with 16'hFFFF while pending -> ignored; commit yields 1,2,3,4.
REQ-035 digit_en=0101 -> slots A and C show disp_sel=0000; B and D are driven; frame length remains 24.
REQ-036 Pending 16'hABCD, then enable=0 -> disp_sel=0000 and A..D=A,B,C,D the next cycle; re-enable -> sequence restarts with 0000 x2, 1000.
REQ-037 Assert reset during slot C with data pending -> all outputs go to reset values immediately; pending is dropped and load_ready=1.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Each digit slot is BLANK_CYCLES of dead time (all anodes off) followed by
// SHOW_CYCLES with that digit's anode driven. New display data is staged in
// a pending register and committed only at a frame boundary, so no frame
// ever mixes old and new digits.
module seven_seg_scan_ctrl #(
  parameter int unsigned SHOW_CYCLES  = 99000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic [3:0]  digit_en,
  output logic        load_ready,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  disp_sel,
  output logic        frame_done
);

  localparam int unsigned MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [0:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sel_q, sel_d;
  logic          pend_q, pend_d;
  logic [15:0]   pdata_q, pdata_d;
  logic [15:0]   digs_q, digs_d;

  // Status outputs are decoded from registers only.
  assign frame_done = (state_q == ST_SHOW) && (idx_q == 2'd3) && (cnt_q == SHOW_LAST);
  assign load_ready = ~pend_q;
  assign disp_sel   = sel_q;
  assign {A, B, C, D} = digs_q;

  // Phase/slot sequencing; the anode select is registered from the next
  // state so digit_en reaches disp_sel one cycle later with no input path.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_BLANK;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else if (state_q == ST_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      if (cnt_q == SHOW_LAST) begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    sel_d = '0;
    if ((state_d == ST_SHOW) && digit_en[2'd3 - idx_d]) begin
      sel_d = 4'b1000 >> idx_d;
    end
  end

  // Pending/commit handling: a commit needs pending data, an accept needs
  // none, so the two can never happen on the same edge.
  always_comb begin
    pend_d  = pend_q;
    pdata_d = pdata_q;
    digs_d  = digs_q;
    if (pend_q && (!enable || frame_done)) begin
      digs_d = pdata_q;
      pend_d = 1'b0;
    end else if (load && !pend_q) begin
      pdata_d = load_data;
      pend_d  = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BLANK;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      sel_q   <= '0;
      pend_q  <= 1'b0;
      pdata_q <= '0;
      digs_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      pdata_q <= pdata_d;
      digs_q  <= digs_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with short slot timing (SHOW=4, BLANK=2).
// Directed run-length vector table, a reset corner case, then random
// stimulus against a frame-position reference model.
module tb_seven_seg_scan_ctrl;

  localparam int SH    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = SH + BL;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] load_data;
  logic [3:0]  digit_en;
  logic        load_ready;
  logic [3:0]  A, B, C, D;
  logic [3:0]  disp_sel;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  seven_seg_scan_ctrl #(.SHOW_CYCLES(SH), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_data(load_data), .digit_en(digit_en), .load_ready(load_ready),
    .A(A), .B(B), .C(C), .D(D), .disp_sel(disp_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Segment: apply the same inputs for n edges, expect the same outputs
  // after each of them.
  typedef struct {
    int          n;
    logic        en;
    logic        ld;
    logic [15:0] data;
    logic [3:0]  de;
    logic [3:0]  disp;
    logic        fd;
    logic        rdy;
    logic [15:0] abcd;
  } seg_t;

  seg_t segs[$];

  // Reference model: position within the frame plus staged/committed data.
  int          m_t;
  logic [3:0]  m_deq;
  logic        m_pend;
  logic [15:0] m_pdata;
  logic [15:0] m_cur;

  task automatic model_reset();
    m_t = 0; m_deq = 4'hF; m_pend = 1'b0; m_pdata = '0; m_cur = '0;
  endtask

  task automatic model_edge(input logic en, input logic ld, input logic [15:0] d,
                            input logic [3:0] de);
    bit fd;
    fd = (m_t == FRAME - 1);
    m_t = en ? (m_t + 1) % FRAME : 0;
    if (m_pend && (!en || fd)) begin
      m_cur = m_pdata; m_pend = 1'b0;
    end else if (ld && !m_pend) begin
      m_pdata = d; m_pend = 1'b1;
    end
    m_deq = de;
  endtask

  task automatic model_check(input int cyc);
    int s, w;
    logic [3:0] ed;
    s = m_t / SLOT;
    w = m_t % SLOT;
    ed = 4'h0;
    if (w >= BL && m_deq[3 - s]) ed = 4'b1000 >> s;
    chk($sformatf("rnd%0d.disp", cyc), {28'h0, disp_sel}, {28'h0, ed});
    chk($sformatf("rnd%0d.fd", cyc), {31'h0, frame_done}, {31'h0, (m_t == FRAME - 1)});
    chk($sformatf("rnd%0d.rdy", cyc), {31'h0, load_ready}, {31'h0, ~m_pend});
    chk($sformatf("rnd%0d.abcd", cyc), {16'h0, A, B, C, D}, {16'h0, m_cur});
  endtask

  task automatic step(input int cyc, input logic en, input logic ld,
                      input logic [15:0] d, input logic [3:0] de);
    enable = en; load = ld; load_data = d; digit_en = de;
    @(posedge clk);
    model_edge(en, ld, d, de);
    @(negedge clk);
    model_check(cyc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".disp"}, {28'h0, disp_sel}, 32'h0);
    chk({tag, ".fd"}, {31'h0, frame_done}, 32'h0);
    chk({tag, ".rdy"}, {31'h0, load_ready}, 32'h1);
    chk({tag, ".abcd"}, {16'h0, A, B, C, D}, 32'h0);
  endtask

  initial begin
    logic en_r, ld_r;
    logic [3:0] de_r;

    //           n  en    ld    data      de    disp  fd    rdy   abcd
    // frame 1: load 1234 mid-slot B, second load ignored, commit at end
    segs.push_back('{1, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b1, 16'h0000});
    segs.push_back('{4, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h8, 1'b0, 1'b1, 16'h0000});
    segs.push_back('{2, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b1, 16'h0000});
    segs.push_back('{2, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h4, 1'b0, 1'b1, 16'h0000});
    segs.push_back('{1, 1'b1, 1'b1, 16'h1234, 4'hF, 4'h4, 1'b0, 1'b0, 16'h0000});
    segs.push_back('{1, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h4, 1'b0, 1'b0, 16'h0000});
    segs.push_back('{1, 1'b1, 1'b1, 16'hFFFF, 4'hF, 4'h0, 1'b0, 1'b0, 16'h0000});
    segs.push_back('{1, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b0, 16'h0000});
    segs.push_back('{4, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h2, 1'b0, 1'b0, 16'h0000});
    segs.push_back('{2, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b0, 16'h0000});
    segs.push_back('{3, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h1, 1'b0, 1'b0, 16'h0000});
    segs.push_back('{1, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h1, 1'b1, 1'b0, 16'h0000});
    // frame 2: digit_en=0101, A and C dark, frame still 24 long
    segs.push_back('{2, 1'b1, 1'b0, 16'h0000, 4'h5, 4'h0, 1'b0, 1'b1, 16'h1234});
    segs.push_back('{4, 1'b1, 1'b0, 16'h0000, 4'h5, 4'h0, 1'b0, 1'b1, 16'h1234});
    segs.push_back('{2, 1'b1, 1'b0, 16'h0000, 4'h5, 4'h0, 1'b0, 1'b1, 16'h1234});
    segs.push_back('{4, 1'b1, 1'b0, 16'h0000, 4'h5, 4'h4, 1'b0, 1'b1, 16'h1234});
    segs.push_back('{2, 1'b1, 1'b0, 16'h0000, 4'h5, 4'h0, 1'b0, 1'b1, 16'h1234});
    segs.push_back('{4, 1'b1, 1'b0, 16'h0000, 4'h5, 4'h0, 1'b0, 1'b1, 16'h1234});
    segs.push_back('{2, 1'b1, 1'b0, 16'h0000, 4'h5, 4'h0, 1'b0, 1'b1, 16'h1234});
    segs.push_back('{3, 1'b1, 1'b0, 16'h0000, 4'h5, 4'h1, 1'b0, 1'b1, 16'h1234});
    segs.push_back('{1, 1'b1, 1'b0, 16'h0000, 4'h5, 4'h1, 1'b1, 1'b1, 16'h1234});
    // pending ABCD, then enable=0 commits at once; re-enable restarts
    segs.push_back('{1, 1'b1, 1'b1, 16'hABCD, 4'hF, 4'h0, 1'b0, 1'b0, 16'h1234});
    segs.push_back('{1, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b0, 16'h1234});
    segs.push_back('{1, 1'b0, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b1, 16'hABCD});
    segs.push_back('{2, 1'b0, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b1, 16'hABCD});
    segs.push_back('{1, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b1, 16'hABCD});
    segs.push_back('{4, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h8, 1'b0, 1'b1, 16'hABCD});
    // stage 5555 and walk into slot C for the reset corner case
    segs.push_back('{1, 1'b1, 1'b1, 16'h5555, 4'hF, 4'h0, 1'b0, 1'b0, 16'hABCD});
    segs.push_back('{1, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b0, 16'hABCD});
    segs.push_back('{4, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h4, 1'b0, 1'b0, 16'hABCD});
    segs.push_back('{2, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b0, 16'hABCD});
    segs.push_back('{2, 1'b1, 1'b0, 16'h0000, 4'hF, 4'h2, 1'b0, 1'b0, 16'hABCD});

    reset = 1'b1; enable = 1'b1; load = 1'b0; load_data = '0; digit_en = 4'hF;
    repeat (2) @(negedge clk);
    chk_reset_vals("in_reset");
    reset = 1'b0;

    foreach (segs[i]) begin
      for (int k = 0; k < segs[i].n; k++) begin
        enable = segs[i].en; load = segs[i].ld;
        load_data = segs[i].data; digit_en = segs[i].de;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("seg%0d.disp", i), {28'h0, disp_sel}, {28'h0, segs[i].disp});
        chk($sformatf("seg%0d.fd", i), {31'h0, frame_done}, {31'h0, segs[i].fd});
        chk($sformatf("seg%0d.rdy", i), {31'h0, load_ready}, {31'h0, segs[i].rdy});
        chk($sformatf("seg%0d.abcd", i), {16'h0, A, B, C, D}, {16'h0, segs[i].abcd});
      end
    end

    // asynchronous reset mid-slot C with 5555 pending
    load = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    // no loads for over a frame: the dropped 5555 must never appear
    for (int c = 0; c < FRAME + 6; c++) step(c, 1'b1, 1'b0, 16'h0, 4'hF);

    // random phase
    en_r = 1'b1; de_r = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      if (en_r && $urandom_range(0, 99) < 2) en_r = 1'b0;
      else if (!en_r && $urandom_range(0, 3) == 0) en_r = 1'b1;
      ld_r = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) de_r = 4'($urandom);
      step(1000 + c, en_r, ld_r, 16'($urandom), de_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
